full_adder_unit: RTL and testbench



---
 rtl/full_adder_bit.sv | 16 +
 rtl/full_adder_unit.sv | 59 +++++
 tb/tb_full_adder_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder cell; the leaf of the ripple-carry chain.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry_out
);

  logic p;

  assign p         = a ^ b;
  assign sum       = p ^ c_in;
  assign carry_out = (a & b) | (c_in & p);

endmodule

// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder: WIDTH chained 1-bit cells feeding one output
// register stage, with carry-out and signed overflow.
module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_core;
  logic [WIDTH-1:0] sum_p0;
  logic             carry_p0;
  logic             ovf_p0;
  logic             vld_p0;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a         (a[i]),
      .b         (b[i]),
      .c_in      (c[i]),
      .sum       (s_core[i]),
      .carry_out (c[i+1])
    );
  end

  // Stage p0: result registers load only on valid input; valid flag tracks every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p0   <= '0;
      carry_p0 <= 1'b0;
      ovf_p0   <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        sum_p0   <= s_core;
        carry_p0 <= c[WIDTH];
        ovf_p0   <= c[WIDTH-1] ^ c[WIDTH];
      end
    end
  end

  assign sum       = sum_p0;
  assign carry_out = carry_p0;
  assign overflow  = ovf_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_full_adder_unit.sv
// Scoreboard bench for full_adder_unit at WIDTH=1, 8 and 16.
module tb_full_adder_unit;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v1 = 1'b0, v8 = 1'b0, v16 = 1'b0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ci1 = 1'b0, ci8 = 1'b0, ci16 = 1'b0;

  logic [0:0]  s1;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic        co1, co8, co16, ov1, ov8, ov16, ovld1, ovld8, ovld16;

  int errors = 0;
  int checks = 0;
  res_t exp_q[$];
  res_t hold_st[3];

  always #5 clk = ~clk;

  full_adder_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c_in(ci1),
    .sum(s1), .carry_out(co1), .overflow(ov1), .out_valid(ovld1));

  full_adder_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c_in(ci8),
    .sum(s8), .carry_out(co8), .overflow(ov8), .out_valid(ovld8));

  full_adder_unit #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .c_in(ci16),
    .sum(s16), .carry_out(co16), .overflow(ov16), .out_valid(ovld16));

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int width_of(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 8 : 16;
  endfunction

  // Reference: integer addition, overflow from operand/result sign bits
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci);
    res_t r;
    logic [16:0] full, m17;
    m17  = (17'd1 << w) - 17'd1;
    full = {1'b0, a & m17[15:0]} + {1'b0, b & m17[15:0]} + {16'd0, ci};
    r.sum  = full[15:0] & m17[15:0];
    r.cout = full[w];
    r.ovf  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    return r;
  endfunction

  function automatic res_t get_out(input int idx);
    res_t r;
    r = '0;
    case (idx)
      0: begin r.sum = {15'd0, s1}; r.cout = co1;  r.ovf = ov1;  end
      1: begin r.sum = {8'd0, s8};  r.cout = co8;  r.ovf = ov8;  end
      default: begin r.sum = s16;   r.cout = co16; r.ovf = ov16; end
    endcase
    return r;
  endfunction

  function automatic logic get_vld(input int idx);
    return (idx == 0) ? ovld1 : (idx == 1) ? ovld8 : ovld16;
  endfunction

  // Drive one cycle at the negedge, then compare the target instance after the edge.
  task automatic step(input string tag, input int idx, input logic r, input logic v,
                      input logic [15:0] a, input logic [15:0] b, input logic ci);
    res_t got, exp;
    logic exp_vld;
    rst = r;
    v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    a1 = '0; b1 = '0; ci1 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    a16 = '0; b16 = '0; ci16 = 1'b0;
    case (idx)
      0: begin v1 = v;  a1 = a[0:0];  b1 = b[0:0];  ci1 = ci;  end
      1: begin v8 = v;  a8 = a[7:0];  b8 = b[7:0];  ci8 = ci;  end
      default: begin v16 = v; a16 = a; b16 = b; ci16 = ci; end
    endcase
    if (v && !r) exp_q.push_back(model(width_of(idx), a, b, ci));
    @(posedge clk);
    #1;
    exp_vld = 1'b0;
    if (r) begin
      for (int k = 0; k < 3; k++) hold_st[k] = '0;
      exp_q.delete();
    end else if (v) begin
      exp_vld = 1'b1;
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 16'd0, 16'd1);
      end else begin
        hold_st[idx] = exp_q.pop_front();
      end
    end
    exp = hold_st[idx];
    got = get_out(idx);
    check({tag, "_sum"},  got.sum, exp.sum);
    check({tag, "_cout"}, {15'd0, got.cout}, {15'd0, exp.cout});
    check({tag, "_ovf"},  {15'd0, got.ovf},  {15'd0, exp.ovf});
    check({tag, "_vld"},  {15'd0, get_vld(idx)}, {15'd0, exp_vld});
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) hold_st[k] = '0;
    @(negedge clk);
    step("rst", 0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_sum", k), get_out(k).sum, 16'd0);
      check($sformatf("rst%0d_cout", k), {15'd0, get_out(k).cout}, 16'd0);
      check($sformatf("rst%0d_ovf", k), {15'd0, get_out(k).ovf}, 16'd0);
      check($sformatf("rst%0d_vld", k), {15'd0, get_vld(k)}, 16'd0);
    end

    // All eight 1-bit vectors back-to-back
    for (int n = 0; n < 8; n++) begin
      logic [2:0] abc;
      abc = 3'(n);
      step($sformatf("w1_v%0d", n), 0, 1'b0, 1'b1,
           {15'd0, abc[2]}, {15'd0, abc[1]}, abc[0]);
    end
    // Independent constant checks of the 1-bit table
    step("w1_111", 0, 1'b0, 1'b1, 16'd1, 16'd1, 1'b1);
    check("w1_111_lit", {14'd0, get_out(0).sum[0], get_out(0).cout}, 16'b11);
    step("w1_001", 0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b1);
    check("w1_001_lit", {13'd0, get_out(0).sum[0], get_out(0).cout, get_out(0).ovf}, 16'b101);

    // 8-bit wrap and signed overflow
    step("w8_wrap", 1, 1'b0, 1'b1, 16'h00FF, 16'h0000, 1'b1);
    check("w8_wrap_lit", {13'd0, get_out(1).sum[7:0] == 8'h00, get_out(1).cout, get_out(1).ovf},
          16'b110);
    step("w8_ovf", 1, 1'b0, 1'b1, 16'h007F, 16'h0001, 1'b0);
    check("w8_ovf_lit", {6'd0, get_out(1).sum[7:0], get_out(1).cout, get_out(1).ovf},
          {6'd0, 8'h80, 1'b0, 1'b1});

    // Hold when in_valid drops
    step("hold_load", 0, 1'b0, 1'b1, 16'd1, 16'd1, 1'b0);
    step("hold_idle", 0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    check("hold_lit", {13'd0, get_out(0).sum[0], get_out(0).cout, ovld1}, 16'b010);
    step("hold_idle2", 0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);

    // Reset wins over in_valid, then same operands load once released
    step("rstprio", 0, 1'b1, 1'b1, 16'd1, 16'd1, 1'b1);
    step("rstrel", 0, 1'b0, 1'b1, 16'd1, 16'd1, 1'b1);
    check("rstrel_lit", {13'd0, get_out(0).sum[0], get_out(0).cout, ovld1}, 16'b111);

    // Random 16-bit traffic with valid gaps
    for (int n = 0; n < 1000; n++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      step("w16_rnd", 2, 1'b0, v, 16'($urandom), 16'($urandom), 1'($urandom));
    end
    step("w16_allones", 2, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    check("w16_allones_lit", {15'd0, get_out(2).cout}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
